// File: rtl/ipsxe_floating_point_seg_carry_adder_v1_0.sv
// ipsxe_floating_point_seg_carry_adder_v1_0
// Pipelined wide adder: o_sum = i_a + i_b + i_cin (mod 2^W), W = SEG_WIDTH*NUM_SEG.
// Each SEG_WIDTH-bit segment adds in its own stage and hands its carry to the
// next stage. Operand segments are skewed on the way in and the partial sums are
// deskewed on the way out, so one full-width result appears per enabled cycle.
// Latency is NUM_SEG + OUT_REG enabled cycles; i_ce=0 freezes every register.
// Optional macro IPSXE_FLOATING_POINT_SEG_ADDSUB_EN adds i_sub (A-B mode).
module ipsxe_floating_point_seg_carry_adder_v1_0 #(
  parameter int SEG_WIDTH = 8,
  parameter int NUM_SEG   = 4,
  parameter int OUT_REG   = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_ce,
  input  logic                         i_valid,
  input  logic [SEG_WIDTH*NUM_SEG-1:0] i_a,
  input  logic [SEG_WIDTH*NUM_SEG-1:0] i_b,
  input  logic                         i_cin,
`ifdef IPSXE_FLOATING_POINT_SEG_ADDSUB_EN
  input  logic                         i_sub,
`endif
  output logic                         o_valid,
  output logic [SEG_WIDTH*NUM_SEG-1:0] o_sum,
  output logic                         o_cout,
  output logic                         o_ovf
);

  localparam int W = SEG_WIDTH * NUM_SEG;
  localparam int L = NUM_SEG + ((OUT_REG != 0) ? 1 : 0);

  // Full-width result assembled from the deskewed segment outputs.
  logic [W-1:0] sum_w;
  logic         cout_w;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SEG; gi++) begin : g_seg
      // Number of cycles this segment's sum must wait for the MSB segment.
      localparam int DESKEW = NUM_SEG - 1 - gi;

      logic [SEG_WIDTH-1:0] a_in;
      logic [SEG_WIDTH-1:0] b_in;
      logic [SEG_WIDTH-1:0] b_eff;
      logic                 c_in;
      logic [SEG_WIDTH:0]   add_d;
      logic [SEG_WIDTH-1:0] sum_q;
      logic                 carry_q;
      logic [SEG_WIDTH-1:0] seg_out;
`ifdef IPSXE_FLOATING_POINT_SEG_ADDSUB_EN
      logic                 sub_in;
`endif

      if (gi == 0) begin : g_head
        // Segment 0 takes the operands and carry-in directly.
        assign a_in = i_a[SEG_WIDTH-1:0];
        assign b_in = i_b[SEG_WIDTH-1:0];
`ifdef IPSXE_FLOATING_POINT_SEG_ADDSUB_EN
        assign sub_in = i_sub;
        // Subtract forms A + ~B + 1, so the external carry-in is ignored.
        assign c_in   = i_sub | i_cin;
`else
        assign c_in   = i_cin;
`endif
      end else begin : g_skew
        logic [SEG_WIDTH-1:0] a_skew_q [gi];
        logic [SEG_WIDTH-1:0] b_skew_q [gi];
`ifdef IPSXE_FLOATING_POINT_SEG_ADDSUB_EN
        logic                 sub_skew_q [gi];
`endif

        // Delay this segment of A/B (and the sub flag) gi cycles to meet its carry.
        always_ff @(posedge i_clk) begin
          if (!i_rst_n) begin
            for (int j = 0; j < gi; j++) begin
              a_skew_q[j] <= '0;
              b_skew_q[j] <= '0;
`ifdef IPSXE_FLOATING_POINT_SEG_ADDSUB_EN
              sub_skew_q[j] <= 1'b0;
`endif
            end
          end else if (i_ce) begin
            a_skew_q[0] <= i_a[gi*SEG_WIDTH +: SEG_WIDTH];
            b_skew_q[0] <= i_b[gi*SEG_WIDTH +: SEG_WIDTH];
`ifdef IPSXE_FLOATING_POINT_SEG_ADDSUB_EN
            sub_skew_q[0] <= i_sub;
`endif
            for (int j = 1; j < gi; j++) begin
              a_skew_q[j] <= a_skew_q[j-1];
              b_skew_q[j] <= b_skew_q[j-1];
`ifdef IPSXE_FLOATING_POINT_SEG_ADDSUB_EN
              sub_skew_q[j] <= sub_skew_q[j-1];
`endif
            end
          end
        end

        assign a_in = a_skew_q[gi-1];
        assign b_in = b_skew_q[gi-1];
        assign c_in = g_seg[gi-1].carry_q;
`ifdef IPSXE_FLOATING_POINT_SEG_ADDSUB_EN
        assign sub_in = sub_skew_q[gi-1];
`endif
      end

`ifdef IPSXE_FLOATING_POINT_SEG_ADDSUB_EN
      // In subtract mode the B segment enters the adder inverted.
      assign b_eff = sub_in ? ~b_in : b_in;
`else
      assign b_eff = b_in;
`endif

      assign add_d = {1'b0, a_in} + {1'b0, b_eff} + {{SEG_WIDTH{1'b0}}, c_in};

      // Segment adder stage: register the partial sum and the carry for the next stage.
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          sum_q   <= '0;
          carry_q <= 1'b0;
        end else if (i_ce) begin
          sum_q   <= add_d[SEG_WIDTH-1:0];
          carry_q <= add_d[SEG_WIDTH];
        end
      end

      if (DESKEW == 0) begin : g_no_deskew
        assign seg_out = sum_q;
      end else begin : g_deskew
        logic [SEG_WIDTH-1:0] deskew_q [DESKEW];

        // Hold early segment sums until the MSB segment of the same operation is done.
        always_ff @(posedge i_clk) begin
          if (!i_rst_n) begin
            for (int j = 0; j < DESKEW; j++) begin
              deskew_q[j] <= '0;
            end
          end else if (i_ce) begin
            deskew_q[0] <= sum_q;
            for (int j = 1; j < DESKEW; j++) begin
              deskew_q[j] <= deskew_q[j-1];
            end
          end
        end

        assign seg_out = deskew_q[DESKEW-1];
      end

      assign sum_w[gi*SEG_WIDTH +: SEG_WIDTH] = seg_out;
    end
  endgenerate

  assign cout_w = g_seg[NUM_SEG-1].carry_q;

  // Sign bits travel with the MSB segment; b uses its post-inversion value so the
  // same equal-signs rule covers both add and subtract.
  logic msb_a_w;
  logic msb_b_w;
  logic msb_s_w;
  logic ovf_d;
  logic ovf_q;

  assign msb_a_w = g_seg[NUM_SEG-1].a_in[SEG_WIDTH-1];
  assign msb_b_w = g_seg[NUM_SEG-1].b_eff[SEG_WIDTH-1];
  assign msb_s_w = g_seg[NUM_SEG-1].add_d[SEG_WIDTH-1];
  assign ovf_d   = (msb_a_w == msb_b_w) && (msb_s_w != msb_a_w);

  // Overflow flag registered alongside the MSB segment's sum and carry.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ovf_q <= 1'b0;
    end else if (i_ce) begin
      ovf_q <= ovf_d;
    end
  end

  // Valid shift pipe, one bit per stage of total latency.
  logic [L-1:0] valid_q;

  // Track i_valid through the full latency; data moves regardless of valid.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q <= '0;
    end else if (i_ce) begin
      valid_q[0] <= i_valid;
      for (int j = 1; j < L; j++) begin
        valid_q[j] <= valid_q[j-1];
      end
    end
  end

  assign o_valid = valid_q[L-1];

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [W-1:0] sum_out_q;
      logic         cout_out_q;
      logic         ovf_out_q;

      // Extra output register stage to decouple the adder chain from downstream logic.
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          sum_out_q  <= '0;
          cout_out_q <= 1'b0;
          ovf_out_q  <= 1'b0;
        end else if (i_ce) begin
          sum_out_q  <= sum_w;
          cout_out_q <= cout_w;
          ovf_out_q  <= ovf_q;
        end
      end

      assign o_sum  = sum_out_q;
      assign o_cout = cout_out_q;
      assign o_ovf  = ovf_out_q;
    end else begin : g_out_direct
      // Last-stage registers drive the outputs directly.
      assign o_sum  = sum_w;
      assign o_cout = cout_w;
      assign o_ovf  = ovf_q;
    end
  endgenerate

endmodule

// File: doc/ipsxe_floating_point_seg_carry_adder_v1_0.md
Name: ipsxe_floating_point_seg_carry_adder_v1_0

Overview:
- Parametrised pipelined wide adder: a W-bit add of i_a + i_b + i_cin, split into NUM_SEG segments of SEG_WIDTH bits.
- Each segment adds in its own pipeline stage and passes its carry to the next stage. This generalises the fixed two-carry segment-high adder used in the invsqrt mantissa datapath.
- Used wherever mantissa/exponent arithmetic exceeds one APM post-adder width.
- Includes valid tracking, a global clock enable, carry-out and signed-overflow flags.

Parameters:
- SEG_WIDTH, 8, bits per segment (1..48).
- NUM_SEG, 4, number of segments/carry stages (1..8); W = SEG_WIDTH*NUM_SEG.
- OUT_REG, 1, 1 = extra output register stage, 0 = outputs taken straight from the last segment stage.

Ports:
- i_clk  input  1  clock, all logic on rising edge
- i_rst_n  input  1  synchronous active-low reset
- i_ce  input  1  global clock enable; low freezes every register
- i_valid  input  1  operand qualifier
- i_a  input  W  operand A (two's complement or unsigned)
- i_b  input  W  operand B
- i_cin  input  1  carry into segment 0
- o_valid  output  1  result qualifier
- o_sum  output  W  A+B+cin mod 2^W
- o_cout  output  1  carry out of MSB segment
- o_ovf  output  1  signed overflow: operand MSBs equal and sum MSB differs

Behaviour:
- Reset: synchronous on i_rst_n==0 at a rising edge, regardless of i_ce.
  - Clears all pipeline valid bits, skew/deskew registers and carry registers.
  - o_valid=0, o_sum=0, o_cout=0, o_ovf=0 from the edge after reset is sampled.
- Latency: L = NUM_SEG + OUT_REG cycles of i_ce=1 from sampling i_valid/i_a/i_b/i_cin to o_valid/o_sum.
  - Throughput is one operation per enabled cycle; there is no back-pressure.
- Stage k (0..NUM_SEG-1):
  - Registers {c_k+1, s_k} = a_k + b_k + c_k (SEG_WIDTH+1-bit add).
  - c_0 = i_cin sampled in stage 0; c_k for k>0 is the carry registered by stage k-1.
- Input skew: segment k of A/B is delayed k cycles by skew registers so it meets c_k.
- Output deskew: s_k is delayed NUM_SEG-1-k cycles so all segments of one operation appear together.
- Sign bookkeeping: the MSBs of a and b travel with the MSB segment to form o_ovf.
- Valid: a 1-bit shift pipe of depth L tracks i_valid.
  - Data registers always shift when i_ce=1, independent of valid.
  - o_sum/o_cout/o_ovf are only meaningful when o_valid=1; no gating to zero.
- i_ce=0: every register, including valid, holds. Outputs remain stable.
  - Operations in flight resume intact when i_ce returns to 1.
- Simultaneous reset and i_ce=0: reset wins.
- Reset mid-operation: all in-flight operations are discarded. No o_valid pulse for operations sampled before reset.
- NUM_SEG=1: degenerates to a single registered adder, L=1+OUT_REG.
- Wrap-around: the sum is modulo 2^W. o_cout carries the bit-W result; o_ovf is independent of o_cout.
- No combinational path from any input to any output when OUT_REG=1.
  - With OUT_REG=0, outputs are driven from the last stage registers, so there is still no input-to-output combinational path.

Optional Feature:
- Macro: IPSXE_FLOATING_POINT_SEG_ADDSUB_EN.
- Defined:
  - Adds input port i_sub (1 bit), sampled with i_valid.
  - When i_sub=1: each segment of i_b is inverted before entering the skew pipe and c_0 = 1 (i_cin ignored), giving o_sum = A-B mod 2^W.
  - o_cout=1 means no borrow.
  - o_ovf uses the inverted B MSB, i.e. overflow = (a_msb != b_msb) && (sum_msb != a_msb).
  - The i_sub flag travels through its own skew register to segment k.
- Undefined: no i_sub port; add-only behaviour as above.

Test Plan (SEG_WIDTH=8, NUM_SEG=4, OUT_REG=1, L=5):
- Full carry ripple: i_a=32'hFFFF_FFFF, i_b=0, i_cin=1, i_valid=1 for one cycle -> after 5 cycles o_valid=1, o_sum=0, o_cout=1, o_ovf=0; o_valid low on the surrounding cycles.
- Signed overflow: i_a=32'h7FFF_FFFF, i_b=32'h0000_0001, i_cin=0 -> o_sum=32'h8000_0000, o_cout=0, o_ovf=1.
- Back-to-back streaming: 16 consecutive random operand pairs with i_valid=1 every cycle -> 16 consecutive o_valid cycles starting at cycle 5; each o_sum matches the reference model, in order.
- Clock-enable freeze: stream 4 operations, drive i_ce=0 for 3 cycles at cycle 2 -> outputs and o_valid hold constant during the freeze; results emerge at cycles 8..11, unchanged.
- Reset mid-flight: issue 3 operations, assert i_rst_n=0 for one cycle at cycle 2 -> o_valid stays 0 for the next 10 cycles and o_sum=0; a new op issued after reset returns correctly at L=5.
- With IPSXE_FLOATING_POINT_SEG_ADDSUB_EN: i_a=32'h0000_0100, i_b=32'h0000_0001, i_sub=1 -> o_sum=32'h0000_00FF, o_cout=1, o_ovf=0; then i_a=0, i_b=1, i_sub=1 -> o_sum=32'hFFFF_FFFF, o_cout=0.
